dc_ramp_ctrl: RTL and testbench

//  Slew-limited sequencer for the 6-bit DC converter configuration code. Sits directly

---
 rtl/dc_pmu_pkg.sv | 14 +
 rtl/dc_ramp_ctrl_if.sv | 36 +++
 rtl/dc_step_timer.sv | 27 ++
 rtl/dc_ramp_ctrl.sv | 135 +++++++++++++
 tb/tb_dc_ramp_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/dc_pmu_pkg.sv
// rtl/dc_pmu_pkg.sv - shared DC converter code width, code type and ramp FSM states
package dc_pmu_pkg;

    localparam int CODE_W = 6;

    typedef logic [CODE_W-1:0] dc_code_t;

    typedef enum logic [1:0] {
        DC_IDLE,
        DC_RAMP,
        DC_SETTLE
    } dc_ramp_state_e;

endpackage

// File: rtl/dc_ramp_ctrl_if.sv
// rtl/dc_ramp_ctrl_if.sv - target request handshake bundle; bypass field only with DC_RAMP_BYPASS_EN
interface dc_ramp_ctrl_if
    import dc_pmu_pkg::*;
#(
    parameter int DIV_W = 8
);

    logic             tgt_valid;
    logic             tgt_ready;
    dc_code_t         tgt_code;
    logic [DIV_W-1:0] step_div;
`ifdef DC_RAMP_BYPASS_EN
    logic             bypass;
`endif

    modport master (
        output tgt_valid,
        output tgt_code,
        output step_div,
`ifdef DC_RAMP_BYPASS_EN
        output bypass,
`endif
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_code,
        input  step_div,
`ifdef DC_RAMP_BYPASS_EN
        input  bypass,
`endif
        output tgt_ready
    );

endinterface

// File: rtl/dc_step_timer.sv
// rtl/dc_step_timer.sv - loadable down-counter pacing one code step per divider period
module dc_step_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dc_ramp_ctrl.sv
// rtl/dc_ramp_ctrl.sv - slew-limited DC converter code sequencer; DC_RAMP_BYPASS_EN enables direct-load bypass
module dc_ramp_ctrl
    import dc_pmu_pkg::*;
#(
    parameter int       DIV_W      = 8,
    parameter int       SETTLE_CYC = 4,
    parameter dc_code_t RESET_CODE = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    dc_ramp_ctrl_if.slave  bus,
    output dc_code_t       code_o,
    output logic           busy_o,
    output logic           done_o
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    dc_ramp_state_e   state_q, state_d;
    dc_code_t         code_q, code_d;
    dc_code_t         tgt_q, tgt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             done_q, done_d;
    logic             byp_q, byp_d;
    logic             byp_in;
    logic             accept;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [DIV_W-1:0] tmr_val;
    dc_code_t         code_step;

`ifdef DC_RAMP_BYPASS_EN
    assign byp_in = bus.bypass;
`else
    assign byp_in = 1'b0;
`endif

    assign bus.tgt_ready = (state_q == DC_IDLE) && en_i && !rst_i;
    assign accept        = bus.tgt_valid && bus.tgt_ready;
    assign code_step     = (tgt_q > code_q) ? code_q + dc_code_t'(1) : code_q - dc_code_t'(1);

    dc_step_timer #(.DIV_W(DIV_W)) u_div_tmr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        tgt_d    = tgt_q;
        div_d    = div_q;
        settle_d = settle_q;
        byp_d    = byp_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = div_q;
        unique case (state_q)
            DC_IDLE: begin
                if (accept) begin
                    tgt_d = bus.tgt_code;
                    div_d = bus.step_div;
                    byp_d = byp_in;
                    if (bus.tgt_code == code_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = DC_RAMP;
                        tmr_load = 1'b1;
                        tmr_val  = bus.step_div;
                    end
                end
            end
            DC_RAMP: begin
                // Disable wins over a due step so the held code is the last one the decoder saw.
                if (!en_i) begin
                    state_d = DC_IDLE;
                end else if (byp_q) begin
                    code_d   = tgt_q;
                    state_d  = DC_SETTLE;
                    settle_d = SET_W'(SETTLE_CYC - 1);
                end else if (tmr_zero) begin
                    code_d   = code_step;
                    tmr_load = 1'b1;
                    if (code_step == tgt_q) begin
                        state_d  = DC_SETTLE;
                        settle_d = SET_W'(SETTLE_CYC - 1);
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DC_SETTLE: begin
                if (!en_i) begin
                    state_d = DC_IDLE;
                end else if (settle_q == '0) begin
                    state_d = DC_IDLE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            default: state_d = DC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= DC_IDLE;
            code_q   <= RESET_CODE;
            tgt_q    <= RESET_CODE;
            div_q    <= '0;
            settle_q <= '0;
            byp_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            tgt_q    <= tgt_d;
            div_q    <= div_d;
            settle_q <= settle_d;
            byp_q    <= byp_d;
            done_q   <= done_d;
        end
    end

    assign code_o = code_q;
    assign busy_o = (state_q != DC_IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_dc_ramp_ctrl.sv
// tb/tb_dc_ramp_ctrl.sv - randomized bench for dc_ramp_ctrl against a closed-form ramp schedule model
module tb_dc_ramp_ctrl;
    import dc_pmu_pkg::*;

    localparam int DIV_W  = 8;
    localparam int SETTLE = 4;

    logic     clk = 1'b0;
    logic     rst;
    logic     en;
    dc_code_t code;
    logic     busy;
    logic     done;

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;

    dc_ramp_ctrl_if #(.DIV_W(DIV_W)) bus ();

    dc_ramp_ctrl #(.DIV_W(DIV_W), .SETTLE_CYC(SETTLE), .RESET_CODE('0)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .bus    (bus),
        .code_o (code),
        .busy_o (busy),
        .done_o (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: after accept edge E0, step n lands on edge E0+n*(div+1); done follows the last step by SETTLE edges.
    // abort_at >= 0 aborts at that sample: mode 0 drops en_i, mode 1 asserts rst_i for two cycles.
    task automatic xfer(input int tgt, input int div, input int abort_at, input bit rst_mode, input bit byp);
        int absd, sgn, total, steps, exp_code;
        absd  = (tgt > cur) ? tgt - cur : cur - tgt;
        sgn   = (tgt > cur) ? 1 : -1;
        if (absd == 0)  total = 0;
        else if (byp)   total = 1 + SETTLE;
        else            total = absd * (div + 1) + SETTLE;
        @(negedge clk);
        chk("ready_idle", int'(bus.tgt_ready), 1);
        bus.tgt_valid = 1'b1;
        bus.tgt_code  = dc_code_t'(tgt);
        bus.step_div  = DIV_W'(div);
`ifdef DC_RAMP_BYPASS_EN
        bus.bypass    = byp;
`endif
        @(posedge clk);
        #1 bus.tgt_valid = 1'b0;
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            if (byp) steps = (k >= 1 && absd != 0) ? absd : 0;
            else     steps = (k / (div + 1) < absd) ? k / (div + 1) : absd;
            exp_code = cur + sgn * steps;
            chk("code", int'(code), exp_code);
            chk("busy", int'(busy), int'(k < total));
            chk("done", int'(done), int'(k == total));
            chk("ready", int'(bus.tgt_ready), int'(k >= total));
            if (k == abort_at && k < total) begin
                bus.tgt_valid = 1'b0;
                if (rst_mode) begin
                    rst = 1'b1;
                    for (int r = 0; r < 2; r++) begin
                        @(negedge clk);
                        chk("rst_code", int'(code), 0);
                        chk("rst_busy", int'(busy), 0);
                        chk("rst_done", int'(done), 0);
                        chk("rst_ready", int'(bus.tgt_ready), 0);
                    end
                    rst = 1'b0;
                    cur = 0;
                end else begin
                    en = 1'b0;
                    @(negedge clk);
                    chk("abort_code", int'(code), exp_code);
                    chk("abort_busy", int'(busy), 0);
                    chk("abort_done", int'(done), 0);
                    chk("abort_ready", int'(bus.tgt_ready), 0);
                    en = 1'b1;
                    cur = exp_code;
                end
                return;
            end
            // Requests presented while busy must be ignored.
            bus.tgt_valid = (k + 1 < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.tgt_code  = dc_code_t'($urandom);
            bus.step_div  = DIV_W'($urandom_range(0, 3));
        end
        bus.tgt_valid = 1'b0;
        cur = tgt;
        @(negedge clk);
        chk("done_pulse_end", int'(done), 0);
        chk("code_hold", int'(code), cur);
    endtask

    initial begin
        int tgt, div, ab;
        bit byp;
        rst = 1'b1;
        en  = 1'b1;
        bus.tgt_valid = 1'b0;
        bus.tgt_code  = '0;
        bus.step_div  = '0;
`ifdef DC_RAMP_BYPASS_EN
        bus.bypass    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_code", int'(code), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(bus.tgt_ready), 0);
        rst = 1'b0;

        xfer(3, 0, -1, 1'b0, 1'b0);
        xfer(10, 1, -1, 1'b0, 1'b0);
        xfer(8, 2, -1, 1'b0, 1'b0);
        xfer(5, 0, -1, 1'b0, 1'b0);
        xfer(5, 3, -1, 1'b0, 1'b0);
        xfer(0, 0, -1, 1'b0, 1'b0);
        xfer(20, 0, 7, 1'b0, 1'b0);
        xfer(9, 0, -1, 1'b0, 1'b0);
        xfer(40, 0, 5, 1'b1, 1'b0);
        xfer(63, 0, -1, 1'b0, 1'b0);
        xfer(0, 0, -1, 1'b0, 1'b0);

        @(negedge clk);
        en = 1'b0;
        bus.tgt_valid = 1'b1;
        bus.tgt_code  = 6'd12;
        @(negedge clk);
        chk("en_low_ready", int'(bus.tgt_ready), 0);
        chk("en_low_busy", int'(busy), 0);
        chk("en_low_code", int'(code), cur);
        bus.tgt_valid = 1'b0;
        en = 1'b1;

`ifdef DC_RAMP_BYPASS_EN
        xfer(63, 0, -1, 1'b0, 1'b1);
        xfer(0, 0, -1, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            tgt = int'($urandom_range(0, 63));
            div = int'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30)) : -1;
`ifdef DC_RAMP_BYPASS_EN
            byp = 1'($urandom_range(0, 3) == 0);
`else
            byp = 1'b0;
`endif
            xfer(tgt, div, ab, 1'($urandom_range(0, 1)), byp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
